// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: start/halt/stall/branch controls in, PC and status out.
//   master : drives start, start_addr, halt, stall, branch_en, branch_abs, target;
//            observes prog_ctr, fetching, done (and cycle_cnt when built with it)
//   slave  : the fetch_pc_unit side of the same signals
// Optional macro: FETCH_CYCLE_COUNT_EN adds the CNT_W parameter and cycle_cnt.
interface fetch_pc_unit_if #(
  parameter int PC_W  = 10
`ifdef FETCH_CYCLE_COUNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            halt;
  logic            stall;
  logic            branch_en;
  logic            branch_abs;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] prog_ctr;
  logic            fetching;
  logic            done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_cnt;
`endif

  modport master (
    output start, start_addr, halt, stall, branch_en, branch_abs, target,
    input  prog_ctr, fetching, done
`ifdef FETCH_CYCLE_COUNT_EN
    , input cycle_cnt
`endif
  );

  modport slave (
    input  start, start_addr, halt, stall, branch_en, branch_abs, target,
    output prog_ctr, fetching, done
`ifdef FETCH_CYCLE_COUNT_EN
    , output cycle_cnt
`endif
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter sequencer for the instruction fetch stage.
// IDLE waits for start, RUN steps the PC (halt > stall > branch > +1),
// DONE parks after halt until the next start.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (state IDLE, PC 0, counter 0)
//   bus : fetch_pc_unit_if.slave -- controls in, prog_ctr/fetching/done out
// Optional macro: FETCH_CYCLE_COUNT_EN adds bus.cycle_cnt, a saturating count
// of RUN cycles (stalls and the halt cycle included), cleared by an accepted start.
module fetch_pc_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          pc_nxt    = bus.start_addr;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: a restart needs a halt first
        if (bus.halt)           state_nxt = DONE;
        else if (bus.stall)     pc_nxt    = pc;
        else if (bus.branch_en) pc_nxt    = bus.branch_abs ? bus.target : pc + bus.target;
        else                    pc_nxt    = pc + 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  // Status is decoded from the state register only, so the two are exclusive.
  assign bus.prog_ctr = pc;
  assign bus.fetching = (state == RUN);
  assign bus.done     = (state == DONE);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  always_comb begin
    cnt_nxt = cnt;
    case (state)
      IDLE, DONE: if (bus.start) cnt_nxt = '0;
      RUN:        if (cnt != '1) cnt_nxt = cnt + 1'b1;
      default:    cnt_nxt = '0;
    endcase
  end

  assign bus.cycle_cnt = cnt;
`else
  // Counter width only matters when the cycle counter is built in.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit. The driver pushes the expected post-edge
// state into a queue; the monitor pops and compares on each falling edge, or
// immediately when the driver signals an asynchronous-reset check.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_CYCLE_COUNT_EN
  fetch_pc_unit_if #(.PC_W(10), .CNT_W(16)) ifc ();
  fetch_pc_unit_if #(.PC_W(10), .CNT_W(4))  ifc4 ();
  fetch_pc_unit #(.PC_W(10), .CNT_W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(ifc4));
  assign ifc4.start      = ifc.start;
  assign ifc4.start_addr = ifc.start_addr;
  assign ifc4.halt       = ifc.halt;
  assign ifc4.stall      = ifc.stall;
  assign ifc4.branch_en  = ifc.branch_en;
  assign ifc4.branch_abs = ifc.branch_abs;
  assign ifc4.target     = ifc.target;
`else
  fetch_pc_unit_if #(.PC_W(10)) ifc ();
`endif

  fetch_pc_unit #(.PC_W(10), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic [9:0] pc;
    logic       f;
    logic       d;
    int         cnt;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event mon_ev;

  // Monitor
  initial begin
    forever begin
      @(negedge clk or mon_ev);
      while (q.size() > 0) begin
        exp_t e;
        logic bad;
        int   got_cnt, got_cnt4, exp_cnt4;
        e        = q.pop_front();
        got_cnt  = -1;
        got_cnt4 = -1;
        exp_cnt4 = (e.cnt > 15) ? 15 : e.cnt;
        bad = (ifc.prog_ctr !== e.pc) || (ifc.fetching !== e.f) || (ifc.done !== e.d);
`ifdef FETCH_CYCLE_COUNT_EN
        got_cnt  = int'(ifc.cycle_cnt);
        got_cnt4 = int'(ifc4.cycle_cnt);
        bad = bad || (ifc.cycle_cnt !== 16'(e.cnt)) || (ifc4.cycle_cnt !== 4'(exp_cnt4));
`endif
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL %s: got pc=%h fetching=%b done=%b cnt=%0d cnt4=%0d, want pc=%h fetching=%b done=%b cnt=%0d cnt4=%0d",
                   e.name, ifc.prog_ctr, ifc.fetching, ifc.done, got_cnt, got_cnt4,
                   e.pc, e.f, e.d, e.cnt, exp_cnt4);
        end
      end
    end
  end

  task automatic push(input logic [9:0] pc, input logic f, input logic d,
                      input int cnt, input string nm);
    exp_t e;
    e.pc = pc; e.f = f; e.d = d; e.cnt = cnt; e.name = nm;
    q.push_back(e);
  endtask

  // One clock of stimulus; expectation is the state after the next rising edge.
  task automatic step(input logic st, input logic [9:0] sa, input logic h, input logic s,
                      input logic be, input logic ba, input logic [9:0] tg,
                      input logic [9:0] epc, input logic ef, input logic ed,
                      input int ecnt, input string nm);
    @(negedge clk);
    ifc.start = st; ifc.start_addr = sa; ifc.halt = h; ifc.stall = s;
    ifc.branch_en = be; ifc.branch_abs = ba; ifc.target = tg;
    @(posedge clk);
    #1 push(epc, ef, ed, ecnt, nm);
  endtask

  task automatic idle(input logic [9:0] epc, input logic ef, input logic ed,
                      input int ecnt, input string nm);
    step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, epc, ef, ed, ecnt, nm);
  endtask

  task automatic jump(input logic [9:0] tg, input int ecnt, input string nm);
    step(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1, tg, tg, 1'b1, 1'b0, ecnt, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.start = 1'b0; ifc.start_addr = '0; ifc.halt = 1'b0; ifc.stall = 1'b0;
    ifc.branch_en = 1'b0; ifc.branch_abs = 1'b0; ifc.target = '0;

    #1 rst = 1'b1;
    #2 push(10'h0, 1'b0, 1'b0, 0, "reset_state");
    ->mon_ev;
    @(negedge clk) rst = 1'b0;

    // Start at 5, then three plain increments
    step(1'b1, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'd5, 1'b1, 1'b0, 0, "start_5");
    idle(10'd6, 1'b1, 1'b0, 1, "inc_6");
    idle(10'd7, 1'b1, 1'b0, 2, "inc_7");
    idle(10'd8, 1'b1, 1'b0, 3, "inc_8");

    // Branches
    jump(10'd20, 4, "abs_20");
    step(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3F0, 10'd4, 1'b1, 1'b0, 5, "rel_neg16");
    jump(10'h007, 6, "abs_7");
    jump(10'd10, 7, "abs_10");

    // Stall beats branch, halt beats everything
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h155, 10'd10, 1'b1, 1'b0, 8, "stall_br_1");
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h155, 10'd10, 1'b1, 1'b0, 9, "stall_br_2");
    step(1'b0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b1, 10'h155, 10'd10, 1'b0, 1'b1, 10, "halt_br");
    idle(10'd10, 1'b0, 1'b1, 10, "done_hold");

    // Restart from DONE; start in RUN ignored
    step(1'b1, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'd2, 1'b1, 1'b0, 0, "restart_2");
    step(1'b1, 10'h100, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'd3, 1'b1, 1'b0, 1, "start_in_run");

    // Wrap cases
    jump(10'h3FF, 2, "abs_3ff");
    idle(10'h000, 1'b1, 1'b0, 3, "wrap_inc");
    jump(10'h3FE, 4, "abs_3fe");
    step(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h003, 10'h001, 1'b1, 1'b0, 5, "wrap_rel");
    jump(10'd9, 6, "abs_9");

    // Asynchronous reset between edges, checked before the next edge
    @(negedge clk);
    #1 rst = 1'b1;
    #1 push(10'h0, 1'b0, 1'b0, 0, "async_reset");
    ->mon_ev;
    @(negedge clk) rst = 1'b0;
    idle(10'h0, 1'b0, 1'b0, 0, "post_reset_idle_1");
    idle(10'h0, 1'b0, 1'b0, 0, "post_reset_idle_2");
    step(1'b1, 10'h01F, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h01F, 1'b1, 1'b0, 0, "start_1f");

    // Six RUN cycles with two stalls, then halt
    idle(10'h020, 1'b1, 1'b0, 1, "cc_run_1");
    idle(10'h021, 1'b1, 1'b0, 2, "cc_run_2");
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0, 10'h021, 1'b1, 1'b0, 3, "cc_stall_1");
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h0, 10'h021, 1'b1, 1'b0, 4, "cc_stall_2");
    idle(10'h022, 1'b1, 1'b0, 5, "cc_run_5");
    idle(10'h023, 1'b1, 1'b0, 6, "cc_run_6");
    step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 10'h023, 1'b0, 1'b1, 7, "cc_halt");
    idle(10'h023, 1'b0, 1'b1, 7, "cc_done_hold");
    step(1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h0, 10'h000, 1'b1, 1'b0, 0, "cc_restart");

    // Twenty RUN cycles: 16-bit counter reaches 20, 4-bit one pins at 15
    for (int k = 1; k <= 20; k++)
      idle(10'(k), 1'b1, 1'b0, k, $sformatf("sat_run_%0d", k));
    step(1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h0, 10'd20, 1'b0, 1'b1, 21, "sat_halt");

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter PC_W, default 10, program-counter and branch-target width.
REQ-002 Parameter CNT_W, default 16, cycle-counter width; used only when the macro of REQ-026 is defined.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  request to begin or restart execution at StartAddr.
REQ-006 StartAddr  input  PC_W  first instruction address.
REQ-007 Halt  input  1  program-complete indication from the decoder.
REQ-008 Stall  input  1  hold the PC for this cycle.
REQ-009 BranchEn  input  1  branch taken this cycle.
REQ-010 BranchAbs  input  1  1 = absolute jump to Target; 0 = PC-relative, PC + Target.
REQ-011 Target  input  PC_W  branch target or offset from the branch lookup table (two's complement when relative).
REQ-012 ProgCtr  output  PC_W  registered address of the current instruction.
REQ-013 Fetching  output  1  high in RUN; ProgCtr addresses a valid instruction.
REQ-014 Done  output  1  high in DONE.
REQ-015 CycleCnt  output  CNT_W  RUN-cycle count; present only with REQ-026.

Function
REQ-016 The FSM SHALL have three states:
- IDLE: on Start, load ProgCtr = StartAddr and go to RUN; otherwise hold.
- RUN: per-cycle priority is Halt > Stall > BranchEn > increment.
- DONE: on Start, load ProgCtr = StartAddr and go to RUN; otherwise hold.
REQ-017 In RUN with Halt=1, the block SHALL hold ProgCtr and go to DONE on the next edge, regardless of Stall and BranchEn.
REQ-018 In RUN with Halt=0 and Stall=1, the block SHALL hold ProgCtr, and BranchEn SHALL be ignored.
REQ-019 In RUN with BranchEn=1 and BranchAbs=1, the next ProgCtr SHALL equal Target.
REQ-020 In RUN with BranchEn=1 and BranchAbs=0, the next ProgCtr SHALL equal (ProgCtr + Target) mod 2^PC_W.
- Example: Target 10'h3F0 at PC 20 yields PC 4.
REQ-021 In RUN with no halt, stall or branch, the next ProgCtr SHALL equal (ProgCtr + 1) mod 2^PC_W; 2^PC_W-1 wraps to 0.
REQ-022 Start asserted while in RUN SHALL be ignored.
REQ-023 Every ProgCtr update SHALL take effect one Clk edge after its inputs are sampled; there is no combinational input-to-ProgCtr path.
REQ-024 Fetching and Done SHALL be decoded from the registered state only and SHALL never be high together.

Reset
REQ-025 Reset assertion SHALL take effect immediately, asynchronously, and set:
- state = IDLE;
- ProgCtr = 0;
- Fetching = 0, Done = 0;
- CycleCnt = 0.
Reset asserted mid-RUN SHALL abandon execution, and after release the block SHALL wait in IDLE for Start.

Configuration
REQ-026 With FETCH_CYCLE_COUNT_EN defined, the block SHALL behave as follows:
- CycleCnt is present.
- Start accepted in IDLE or DONE clears CycleCnt to 0.
- CycleCnt increments once per RUN cycle, including stalled cycles and the Halt cycle.
- CycleCnt saturates at 2^CNT_W-1.
- CycleCnt holds in IDLE and DONE.
REQ-027 Without FETCH_CYCLE_COUNT_EN, port CycleCnt and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Reset, then Start with StartAddr=5, then 3 idle cycles -> ProgCtr 5,6,7,8; Fetching=1; Done=0.
- PC=20, BranchEn=1, BranchAbs=0, Target=10'h3F0 -> next ProgCtr=4. PC=4, BranchAbs=1, Target=10'h007 -> next ProgCtr=7.
- PC=10, Stall=1 and BranchEn=1 together for 2 cycles -> ProgCtr stays 10. Then Halt=1 with BranchEn=1 -> ProgCtr stays 10, Done=1 next cycle, Fetching=0.
- PC=10'h3FF, increment -> ProgCtr=0. PC=10'h3FE, relative Target=10'h003 -> ProgCtr=1.
- Reset pulsed mid-RUN at PC=9 -> ProgCtr=0 and state IDLE immediately, before the next edge. Start while in RUN -> ignored. Start in DONE with StartAddr=2 -> RUN at PC 2.
- With FETCH_CYCLE_COUNT_EN: Start, 6 RUN cycles incl. 2 stalls, then Halt -> CycleCnt=7, held in DONE, cleared to 0 on restart. With CNT_W=4 and 20 RUN cycles -> CycleCnt=15.
